id_ex_pipe_reg: RTL and testbench
=================================

Name: id_ex_pipe_reg

Overview:
- Parametrised decode-to-execute pipeline register for the 24-bit processor.
- Carries operands, immediate, destination address and control from decode to execute.
- Compared with a plain capture register, it adds:
  - a valid bit;
  - stall (hold) and flush (bubble) controls;
  - built-in load-use hazard detection that inserts a bubble and requests an upstream stall;
  - saturating stall and bubble performance counters.
- Sits between the register file/decoder and the ALU stage.

Parameters:
- DATA_W, 24, width of operands and extended immediate.
- REG_AW, 4, register address width.
- ALUCTRL_W, 2, ALU control field width.
- CNT_W, 16, width of each performance counter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- stall  input  1  hold all stage contents this cycle.
- flush  input  1  replace next stage contents with a bubble.
- clr_cnt  input  1  synchronous clear of both counters.
- valid_d  input  1  decode stage holds a real instruction.
- rd1  input  DATA_W  register-file read data 1.
- rd2  input  DATA_W  register-file read data 2.
- ra1_d  input  REG_AW  source address 1 of the decode instruction.
- ra2_d  input  REG_AW  source address 2 of the decode instruction.
- ra3  input  REG_AW  destination address.
- extend  input  DATA_W  extended immediate.
- regWrite  input  1  decode control bit.
- aluSrc  input  1  decode control bit.
- PCSrc  input  1  decode control bit.
- memToReg  input  1  decode control bit.
- memWrite  input  1  decode control bit.
- aluControl  input  ALUCTRL_W  ALU operation select.
- SrcA  output  DATA_W  registered rd1.
- SrcB  output  DATA_W  registered rd2.
- ExtImm  output  DATA_W  registered extend.
- WA3E  output  REG_AW  registered ra3.
- regWriteE  output  1  registered control.
- aluSrcE  output  1  registered control.
- PCSrcE  output  1  registered control.
- memToRegE  output  1  registered control.
- memWriteE  output  1  registered control.
- aluControlE  output  ALUCTRL_W  registered control.
- valid_e  output  1  execute stage holds a real instruction.
- load_use_stall  output  1  combinational; upstream must hold fetch/decode this cycle.
- stall_cnt  output  CNT_W  cycles with stall asserted.
- bubble_cnt  output  CNT_W  bubbles inserted.

Behaviour:
- Reset:
  - rst asynchronous, active-high; clock is clk.
  - Every registered output goes to 0 on rst: all data, WA3E, all control, valid_e, both counters.
  - Reset mid-operation discards the in-flight instruction immediately, without waiting for a clock edge.
- Latency: one cycle from the decode inputs to the E outputs.
- Hazard detect (combinational, from current registered state):
  - load_use_stall = valid_e & memToRegE & regWriteE & valid_d & ((WA3E == ra1_d) | (WA3E == ra2_d)).
  - No register address is excluded from the compare.
- Per-edge update, in priority order:
  1. flush = 1: capture a bubble.
  2. stall = 1 (flush = 0): hold every stage register unchanged, including valid_e.
  3. load_use_stall = 1: capture a bubble.
  4. Otherwise: capture all inputs; valid_e <= valid_d.
- Bubble contents:
  - valid_e = 0.
  - regWriteE, memWriteE, PCSrcE, memToRegE, aluSrcE = 0.
  - aluControlE = 0.
  - SrcA, SrcB, ExtImm, WA3E = 0.
- Side-effect guarantee: a bubble produces no architectural side effect downstream.
- Capture with valid_d = 0: inputs are captured normally but valid_e = 0. This counts as a normal capture, not a bubble.
- Load-use resolution: after the one-cycle bubble, valid_e = 0, so load_use_stall drops the next cycle and the held decode instruction is captured normally.
- Stall and hazard together: while stall = 1, the stage holds. load_use_stall stays asserted (state unchanged), so upstream stays held.
- Counters (saturating):
  - stall_cnt increments every edge with stall = 1 (including when flush = 1), saturating at 2^CNT_W - 1.
  - bubble_cnt increments every edge on which a bubble is captured (flush, or hazard-driven), saturating at 2^CNT_W - 1.
  - clr_cnt = 1 zeroes both counters on that edge. It overrides any increment that edge and does not affect pipeline state.
- Output timing: all outputs except load_use_stall are registered; no combinational path from inputs to registered outputs.

Test Plan:
1. Reset:
   - Stimulus: drive all inputs nonzero (rd1 = 24'hABCDEF, regWrite = 1, valid_d = 1); assert rst between clock edges.
   - Required response: all outputs 0 immediately; after release, next edge gives SrcA = 24'hABCDEF, valid_e = 1.
2. Stall hold:
   - Stimulus: load rd1 = 24'h000123, then stall = 1 for 3 cycles while rd1 = 24'hFFFFFF.
   - Required response: SrcA stays 24'h000123; stall_cnt = 3.
3. Flush priority:
   - Stimulus: flush = 1 and stall = 1 on the same edge with memWriteE previously 1.
   - Required response: memWriteE = 0, valid_e = 0, SrcA = 0; bubble_cnt = 1; stall_cnt = 1.
4. Load-use hazard:
   - Stimulus: capture a load (memToReg = 1, regWrite = 1, ra3 = 4'd5); next decode has ra2_d = 5.
   - Required response: load_use_stall = 1; next edge captures a bubble (valid_e = 0); load_use_stall = 0 afterwards; following edge captures the dependent instruction. bubble_cnt = 1.
5. No false hazard:
   - Case A: load to r5 with ra1_d = 6, ra2_d = 7. Required response: load_use_stall = 0.
   - Case B: non-load (memToReg = 0) writing r5 with ra1_d = 5. Required response: load_use_stall = 0.
6. Counter saturation and clear:
   - Stimulus: CNT_W = 4, stall held 20 cycles; then clr_cnt = 1 and stall = 1 on the same edge.
   - Required response: stall_cnt = 15 after 20 cycles; stall_cnt = 0 after the clr_cnt edge.

Source files
------------

// File: rtl/id_ex_pipe_reg.sv
// ---------------------------------------------------------------------------
// id_ex_pipe_reg
// Decode-to-execute pipeline register for the 24-bit processor, placed
// between the register file/decoder and the ALU stage.
//
// Besides capturing operands, immediate, destination and control, it:
//   - carries a valid bit alongside the data;
//   - holds on stall and inserts a bubble on flush;
//   - detects a load-use hazard against the instruction now in execute,
//     inserts a bubble and asks upstream to hold fetch/decode;
//   - keeps saturating counts of stall cycles and inserted bubbles.
//
// Ports
//   clk, rst          clock; asynchronous active-high reset
//   stall, flush      hold stage / replace next contents with a bubble
//   clr_cnt           synchronous clear of both performance counters
//   valid_d           decode stage holds a real instruction
//   rd1, rd2, extend  operands and extended immediate from decode
//   ra1_d, ra2_d      source addresses of the decode instruction
//   ra3               destination address
//   regWrite, aluSrc, PCSrc, memToReg, memWrite, aluControl  decode control
//   SrcA, SrcB, ExtImm, WA3E, *E   registered execute-stage copies
//   valid_e           execute stage holds a real instruction
//   load_use_stall    combinational upstream hold request
//   stall_cnt         saturating count of cycles with stall asserted
//   bubble_cnt        saturating count of bubbles inserted
// ---------------------------------------------------------------------------
module id_ex_pipe_reg #(
   parameter int DATA_W    = 24,
   parameter int REG_AW    = 4,
   parameter int ALUCTRL_W = 2,
   parameter int CNT_W     = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 stall,
   input  logic                 flush,
   input  logic                 clr_cnt,
   input  logic                 valid_d,
   input  logic [DATA_W-1:0]    rd1,
   input  logic [DATA_W-1:0]    rd2,
   input  logic [REG_AW-1:0]    ra1_d,
   input  logic [REG_AW-1:0]    ra2_d,
   input  logic [REG_AW-1:0]    ra3,
   input  logic [DATA_W-1:0]    extend,
   input  logic                 regWrite,
   input  logic                 aluSrc,
   input  logic                 PCSrc,
   input  logic                 memToReg,
   input  logic                 memWrite,
   input  logic [ALUCTRL_W-1:0] aluControl,
   output logic [DATA_W-1:0]    SrcA,
   output logic [DATA_W-1:0]    SrcB,
   output logic [DATA_W-1:0]    ExtImm,
   output logic [REG_AW-1:0]    WA3E,
   output logic                 regWriteE,
   output logic                 aluSrcE,
   output logic                 PCSrcE,
   output logic                 memToRegE,
   output logic                 memWriteE,
   output logic [ALUCTRL_W-1:0] aluControlE,
   output logic                 valid_e,
   output logic                 load_use_stall,
   output logic [CNT_W-1:0]     stall_cnt,
   output logic [CNT_W-1:0]     bubble_cnt
);

   logic [DATA_W-1:0]    srca_p1, srcb_p1, ext_p1;
   logic [REG_AW-1:0]    wa3_p1;
   logic                 regwrite_p1, alusrc_p1, pcsrc_p1, memtoreg_p1, memwrite_p1;
   logic [ALUCTRL_W-1:0] aluctrl_p1;
   logic                 vld_p1;
   logic [CNT_W-1:0]     stall_cnt_q, bubble_cnt_q;
   logic                 bubble;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return (&c) ? c : c + {{(CNT_W-1){1'b0}}, 1'b1};
   endfunction

   // A load in execute whose destination matches either source of the
   // decode instruction cannot forward in time; r0 is not special here.
   assign load_use_stall = vld_p1 & memtoreg_p1 & regwrite_p1 & valid_d &
                           ((wa3_p1 == ra1_d) | (wa3_p1 == ra2_d));

   // Flush beats stall; the hazard bubble only happens when not stalled,
   // otherwise the stage holds and the hazard stays visible upstream.
   assign bubble = flush | (~stall & load_use_stall);

   // ---- decode -> execute stage boundary ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst || bubble) begin
         srca_p1     <= '0;
         srcb_p1     <= '0;
         ext_p1      <= '0;
         wa3_p1      <= '0;
         regwrite_p1 <= 1'b0;
         alusrc_p1   <= 1'b0;
         pcsrc_p1    <= 1'b0;
         memtoreg_p1 <= 1'b0;
         memwrite_p1 <= 1'b0;
         aluctrl_p1  <= '0;
         vld_p1      <= 1'b0;
      end else if (!stall) begin
         srca_p1     <= rd1;
         srcb_p1     <= rd2;
         ext_p1      <= extend;
         wa3_p1      <= ra3;
         regwrite_p1 <= regWrite;
         alusrc_p1   <= aluSrc;
         pcsrc_p1    <= PCSrc;
         memtoreg_p1 <= memToReg;
         memwrite_p1 <= memWrite;
         aluctrl_p1  <= aluControl;
         vld_p1      <= valid_d;
      end
   end

   // ---- performance counters ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt_q  <= '0;
         bubble_cnt_q <= '0;
      end else if (clr_cnt) begin
         stall_cnt_q  <= '0;
         bubble_cnt_q <= '0;
      end else begin
         if (stall)
            stall_cnt_q <= sat_inc(stall_cnt_q);
         if (bubble)
            bubble_cnt_q <= sat_inc(bubble_cnt_q);
      end
   end

   assign SrcA        = srca_p1;
   assign SrcB        = srcb_p1;
   assign ExtImm      = ext_p1;
   assign WA3E        = wa3_p1;
   assign regWriteE   = regwrite_p1;
   assign aluSrcE     = alusrc_p1;
   assign PCSrcE      = pcsrc_p1;
   assign memToRegE   = memtoreg_p1;
   assign memWriteE   = memwrite_p1;
   assign aluControlE = aluctrl_p1;
   assign valid_e     = vld_p1;
   assign stall_cnt   = stall_cnt_q;
   assign bubble_cnt  = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
module tb_id_ex_pipe_reg;
   localparam int CNT_W = 4;
   localparam int MAXC  = (1 << CNT_W) - 1;

   logic clk = 1'b0, rst = 1'b0;
   logic stall = 0, flush = 0, clr_cnt = 0, valid_d = 0;
   logic [23:0] rd1 = 0, rd2 = 0, extend = 0;
   logic [3:0]  ra1_d = 0, ra2_d = 0, ra3 = 0;
   logic regWrite = 0, aluSrc = 0, PCSrc = 0, memToReg = 0, memWrite = 0;
   logic [1:0]  aluControl = 0;
   logic [23:0] SrcA, SrcB, ExtImm;
   logic [3:0]  WA3E;
   logic regWriteE, aluSrcE, PCSrcE, memToRegE, memWriteE, valid_e, load_use_stall;
   logic [1:0]  aluControlE;
   logic [CNT_W-1:0] stall_cnt, bubble_cnt;

   id_ex_pipe_reg #(.DATA_W(24), .REG_AW(4), .ALUCTRL_W(2), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush), .clr_cnt(clr_cnt),
      .valid_d(valid_d), .rd1(rd1), .rd2(rd2), .ra1_d(ra1_d), .ra2_d(ra2_d),
      .ra3(ra3), .extend(extend), .regWrite(regWrite), .aluSrc(aluSrc),
      .PCSrc(PCSrc), .memToReg(memToReg), .memWrite(memWrite),
      .aluControl(aluControl), .SrcA(SrcA), .SrcB(SrcB), .ExtImm(ExtImm),
      .WA3E(WA3E), .regWriteE(regWriteE), .aluSrcE(aluSrcE), .PCSrcE(PCSrcE),
      .memToRegE(memToRegE), .memWriteE(memWriteE), .aluControlE(aluControlE),
      .valid_e(valid_e), .load_use_stall(load_use_stall),
      .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt));

   always #5 clk = ~clk;

   typedef struct packed {
      logic v, rw, as, pc, mr, mw;
      logic [1:0] alu;
      logic [3:0] wa;
      logic [23:0] a, b, imm;
   } state_t;

   typedef struct packed {
      logic valid_d;
      logic [23:0] rd1, rd2, ext;
      logic [3:0] ra1, ra2, ra3;
      logic rw, as, pc, mr, mw;
      logic [1:0] alu;
      logic stall, flush, clr;
   } stim_t;

   typedef struct packed {
      logic luse;
      state_t st;
      logic [CNT_W-1:0] sc, bc;
   } exp_t;

   exp_t q[$];
   state_t m;          // reference model: what execute should hold
   int m_sc, m_bc;     // reference counter values
   int n_vec = 0, n_err = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic state_t dut_st();
      return {valid_e, regWriteE, aluSrcE, PCSrcE, memToRegE, memWriteE,
              aluControlE, WA3E, SrcA, SrcB, ExtImm};
   endfunction

   task automatic apply(input stim_t s);
      valid_d = s.valid_d; rd1 = s.rd1; rd2 = s.rd2; extend = s.ext;
      ra1_d = s.ra1; ra2_d = s.ra2; ra3 = s.ra3;
      regWrite = s.rw; aluSrc = s.as; PCSrc = s.pc; memToReg = s.mr;
      memWrite = s.mw; aluControl = s.alu;
      stall = s.stall; flush = s.flush; clr_cnt = s.clr;
   endtask

   // Advance the model by one clock edge and queue what the DUT should show.
   task automatic model_step(input stim_t s);
      exp_t e;
      logic hazard, make_bubble;
      hazard = m.v && m.mr && m.rw && s.valid_d && (m.wa == s.ra1 || m.wa == s.ra2);
      e.luse = hazard;
      make_bubble = s.flush || (!s.stall && hazard);
      if (s.stall && m_sc < MAXC) m_sc++;
      if (make_bubble) begin
         m = '0;
         if (m_bc < MAXC) m_bc++;
      end else if (!s.stall) begin
         m = {s.valid_d, s.rw, s.as, s.pc, s.mr, s.mw, s.alu, s.ra3, s.rd1, s.rd2, s.ext};
      end
      if (s.clr) begin m_sc = 0; m_bc = 0; end
      e.st = m;
      e.sc = CNT_W'(m_sc);
      e.bc = CNT_W'(m_bc);
      q.push_back(e);
   endtask

   task automatic cyc(input stim_t s);
      @(negedge clk);
      apply(s);
      #1 model_step(s);
   endtask

   // Reset asserted between edges with the given inputs already driven.
   task automatic do_reset(input stim_t s);
      @(negedge clk);
      apply(s);
      #1 rst = 1'b1;
      #1 chk("rst_async_state", dut_st(), '0);
      chk("rst_async_cnt", {stall_cnt, bubble_cnt}, '0);
      rst = 1'b0;
      m = '0; m_sc = 0; m_bc = 0;
      #1 model_step(s);
   endtask

   task automatic after_edge();
      @(posedge clk);
      #2;
   endtask

   // Monitor: sample the hazard output late in the cycle, then compare the
   // registered outputs just after the edge against the queued expectation.
   initial begin
      logic luse_s;
      exp_t e;
      forever begin
         @(negedge clk);
         #4 luse_s = load_use_stall;
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("load_use_stall", luse_s, e.luse);
            chk("stage_state", dut_st(), e.st);
            chk("stall_cnt", stall_cnt, e.sc);
            chk("bubble_cnt", bubble_cnt, e.bc);
         end
      end
   end

   initial begin
      stim_t s;
      m = '0; m_sc = 0; m_bc = 0;
      #1 rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1 chk("reset_state", dut_st(), '0);
      chk("reset_cnt", {stall_cnt, bubble_cnt}, '0);
      chk("reset_luse", load_use_stall, 1'b0);

      // Reset while inputs are live, then first capture.
      s = '0;
      s.valid_d = 1; s.rd1 = 24'hABCDEF; s.rd2 = 24'h123456; s.ext = 24'h654321;
      s.ra1 = 4'd1; s.ra2 = 4'd2; s.ra3 = 4'd3;
      s.rw = 1; s.as = 1; s.pc = 1; s.mr = 1; s.mw = 1; s.alu = 2'd3;
      do_reset(s);
      after_edge();
      chk("t1_SrcA", SrcA, 24'hABCDEF);
      chk("t1_valid_e", valid_e, 1'b1);

      // Stall hold.
      s = '0; s.valid_d = 1; s.rd1 = 24'h000123; s.clr = 1;
      cyc(s);
      s.clr = 0; s.rd1 = 24'hFFFFFF; s.stall = 1;
      repeat (3) cyc(s);
      after_edge();
      chk("t2_SrcA_held", SrcA, 24'h000123);
      chk("t2_stall_cnt", stall_cnt, 4'd3);

      // Flush wins over stall.
      s = '0; s.valid_d = 1; s.rd1 = 24'h000055; s.mw = 1; s.clr = 1;
      cyc(s);
      s = '0; s.valid_d = 1; s.rd1 = 24'h000099; s.mw = 1; s.flush = 1; s.stall = 1;
      cyc(s);
      after_edge();
      chk("t3_memWriteE", memWriteE, 1'b0);
      chk("t3_valid_e", valid_e, 1'b0);
      chk("t3_SrcA", SrcA, 24'h0);
      chk("t3_bubble_cnt", bubble_cnt, 4'd1);
      chk("t3_stall_cnt", stall_cnt, 4'd1);

      // Load-use hazard: bubble once, then the dependent goes through.
      s = '0; s.valid_d = 1; s.mr = 1; s.rw = 1; s.ra3 = 4'd5; s.clr = 1;
      cyc(s);
      s = '0; s.valid_d = 1; s.ra1 = 4'd1; s.ra2 = 4'd5; s.rd1 = 24'h000777; s.ra3 = 4'd9;
      cyc(s);
      chk("t4_luse_high", load_use_stall, 1'b1);
      after_edge();
      chk("t4_bubble_valid", valid_e, 1'b0);
      cyc(s);
      chk("t4_luse_low", load_use_stall, 1'b0);
      after_edge();
      chk("t4_dep_valid", valid_e, 1'b1);
      chk("t4_dep_SrcA", SrcA, 24'h000777);
      chk("t4_bubble_cnt", bubble_cnt, 4'd1);

      // No false hazards.
      s = '0; s.valid_d = 1; s.mr = 1; s.rw = 1; s.ra3 = 4'd5;
      cyc(s);
      s = '0; s.valid_d = 1; s.ra1 = 4'd6; s.ra2 = 4'd7; s.rw = 1; s.ra3 = 4'd5;
      cyc(s);
      chk("t5a_luse", load_use_stall, 1'b0);
      s = '0; s.valid_d = 1; s.ra1 = 4'd5; s.ra2 = 4'd5;
      cyc(s);
      chk("t5b_luse", load_use_stall, 1'b0);

      // Counter saturation and clear.
      s = '0; s.clr = 1;
      cyc(s);
      s = '0; s.stall = 1;
      repeat (20) cyc(s);
      after_edge();
      chk("t6_stall_sat", stall_cnt, 4'd15);
      s.clr = 1;
      cyc(s);
      after_edge();
      chk("t6_stall_clr", stall_cnt, 4'd0);

      // Randomised traffic, biased so sources often hit the execute destination.
      for (int i = 0; i < 400; i++) begin
         s = '0;
         s.valid_d = ($urandom_range(3) != 0);
         s.rd1 = 24'($urandom); s.rd2 = 24'($urandom); s.ext = 24'($urandom);
         s.ra1 = ($urandom_range(2) == 0) ? m.wa : 4'($urandom);
         s.ra2 = ($urandom_range(2) == 0) ? m.wa : 4'($urandom);
         s.ra3 = 4'($urandom);
         s.rw = 1'($urandom); s.as = 1'($urandom); s.pc = 1'($urandom);
         s.mr = 1'($urandom); s.mw = 1'($urandom); s.alu = 2'($urandom);
         s.stall = ($urandom_range(4) == 0);
         s.flush = ($urandom_range(9) == 0);
         s.clr = ($urandom_range(24) == 0);
         cyc(s);
      end

      repeat (2) @(posedge clk);
      #3 chk("scoreboard_drained", 128'(q.size()), '0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
